// File: rtl/gf251_inv.sv
// Purpose : GF(251) multiplicative inverse, out = in^249 mod 251, by left-to-right square-and-multiply.
// Latency : 12 cycles from the accepting edge to the done pulse; a new operand can be accepted 13 cycles apart.
// Backpr. : no queueing; start is ignored while busy, and the caller retries after done.
module gf251_inv (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       start,
   input  logic [7:0] in,
   output logic [7:0] out,
   output logic       done,
   output logic       busy,
   output logic       zero_err
);

   // Fermat exponent p-2. Bit 7 is consumed by loading acc with the base,
   // so the walk covers bits 6..0.
   localparam logic [7:0] EXP     = 8'd249;
   localparam logic [7:0] MODULUS = 8'd251;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Reset: asserts asynchronously and releases synchronously, so every
   // flop below leaves reset on the same clock edge.
   // ------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   // Two-stage release synchroniser for the external reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t     state_q,    state_d;
   logic [7:0] base_q,     base_d;
   logic [7:0] acc_q,      acc_d;
   logic [2:0] idx_q,      idx_d;
   logic [7:0] out_q,      out_d;
   logic       done_q,     done_d;
   logic       busy_q,     busy_d;
   logic       zero_err_q, zero_err_d;

   // ------------------------------------------------------------------
   // Shared mod-251 multiplier. It squares in SQR and multiplies by the
   // base in MUL. Reduction uses 256 = 5 (mod 251): fold the high byte
   // twice, then apply one conditional subtraction.
   //   product <= 250*250 = 62500
   //   fold1   <= 244*5 + 255 = 1475   (11 bits, top 3 bits <= 5)
   //   fold2   <= 5*5 + 255   = 280    (one subtraction is enough)
   // ------------------------------------------------------------------
   logic [7:0]  mul_b;
   logic [15:0] mul_prod;
   logic [10:0] mul_fold1;
   logic [8:0]  mul_fold2;
   logic [8:0]  mul_sub;
   logic [7:0]  mul_r;

   // Operand select and modular reduction of the 16-bit product.
   always_comb begin
      mul_b     = (state_q == MUL) ? base_q : acc_q;
      mul_prod  = 16'(acc_q) * 16'(mul_b);
      mul_fold1 = 11'(mul_prod[7:0]) + (11'(mul_prod[15:8]) * 11'd5);
      mul_fold2 = 9'(mul_fold1[7:0]) + (9'(mul_fold1[10:8]) * 9'd5);
      mul_sub   = mul_fold2 - 9'(MODULUS);
      if (mul_fold2 >= 9'(MODULUS)) begin
         mul_r = mul_sub[7:0];
      end else begin
         mul_r = mul_fold2[7:0];
      end
   end

   // Operand reduction at capture: 251..255 fold down to 0..4.
   logic [7:0] in_red;

   // Map the raw operand into [0,250].
   always_comb begin
      if (in >= MODULUS) begin
         in_red = in - MODULUS;
      end else begin
         in_red = in;
      end
   end

   // ------------------------------------------------------------------
   // FSM register, plus the datapath registers it steers.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q    <= IDLE;
         base_q     <= 8'd0;
         acc_q      <= 8'd0;
         idx_q      <= 3'd0;
         out_q      <= 8'd0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         out_q      <= out_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         zero_err_q <= zero_err_d;
      end
   end

   // Next-state logic. The walk covers bits 6..0 of the exponent: every
   // bit squares, and each set bit adds a multiply by the base. Bit 0 is
   // set, so the run always ends in MUL with idx = 0.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      out_d      = out_q;
      done_d     = 1'b0;
      busy_d     = busy_q;
      zero_err_d = zero_err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = in_red;
               acc_d   = in_red;
               idx_d   = 3'd6;
               busy_d  = 1'b1;
               state_d = SQR;
            end
         end

         SQR: begin
            acc_d = mul_r;
            if (EXP[idx_q]) begin
               state_d = MUL;
            end else begin
               idx_d = idx_q - 3'd1;
            end
         end

         MUL: begin
            acc_d = mul_r;
            if (idx_q == 3'd0) begin
               out_d      = mul_r;
               done_d     = 1'b1;
               zero_err_d = (base_q == 8'd0);
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               idx_d   = idx_q - 3'd1;
               state_d = SQR;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign out      = out_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign zero_err = zero_err_q;

endmodule

// File: tb/tb_gf251_inv.sv
// Testbench for gf251_inv: directed steps plus random operands.
// Expected results come from a plain modular-exponent reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_gf251_inv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] din = 8'd0;
   logic [7:0] dout;
   logic       done;
   logic       busy;
   logic       zero_err;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   gf251_inv dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .start    (start),
      .in       (din),
      .out      (dout),
      .done     (done),
      .busy     (busy),
      .zero_err (zero_err)
   );

   // Reference model: reduce the operand mod 251, then raise it to the
   // power 249 by repeated multiplication.
   function automatic int ref_inv(input int a);
      int x;
      int r;
      x = a % 251;
      r = 1;
      for (int i = 0; i < 249; i++) r = (r * x) % 251;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete operation. The caller is idle, sampling just after an edge.
   task automatic run_op(input logic [7:0] a, output logic [7:0] res);
      int  k;
      bit  seen;
      start = 1'b1;
      din   = a;
      step();                                   // accepting edge E0
      chk("accept_busy", 32'(busy), 1);
      start = 1'b0;
      din   = 8'($urandom);
      seen  = 1'b0;
      k     = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         step();
         if (done === 1'b1) begin
            seen = 1'b1;
            k    = c;
         end
      end
      chk("latency", 32'(k), 12);
      res = dout;
      chk("result", 32'(dout), 32'(ref_inv(int'(a))));
      chk("zero_err", 32'(zero_err), 32'((int'(a) % 251) == 0));
      chk("busy_at_done", 32'(busy), 0);
      step();
      chk("done_one_cycle", 32'(done), 0);
   endtask

   logic [7:0] res;
   logic [7:0] vals [0:63];
   int         ndone;
   int         dcyc;
   bit         seen2;

   initial begin
      // ---- reset, then idle ----
      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_out", 32'(dout), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_zero_err", 32'(zero_err), 0);
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_done", 32'(done), 0);
         chk("idle_busy", 32'(busy), 0);
      end

      // ---- directed single operations ----
      run_op(8'd1, res);   chk("inv1", 32'(res), 1);
      run_op(8'd2, res);   chk("inv2", 32'(res), 126);
      run_op(8'd20, res);  chk("inv20", 32'(res), 113);
      run_op(8'd34, res);  chk("inv34", 32'(res), 96);
      run_op(8'd250, res); chk("inv250", 32'(res), 250);

      // ---- edge operands ----
      run_op(8'd0, res);   chk("inv0", 32'(res), 0);   chk("zerr0", 32'(zero_err), 1);
      run_op(8'd251, res); chk("inv251", 32'(res), 0); chk("zerr251", 32'(zero_err), 1);
      run_op(8'd252, res); chk("inv252", 32'(res), 1); chk("zerr252", 32'(zero_err), 0);

      // ---- start while busy is ignored ----
      start = 1'b1;
      din   = 8'd2;
      step();                                   // E0
      start = 1'b0;
      ndone = 0;
      dcyc  = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (done === 1'b1) begin
            ndone++;
            dcyc = c;
         end
         if (c == 2 || c == 10 || c == 12) begin
            start = 1'b1;
            din   = 8'd34;
         end else begin
            start = 1'b0;
            din   = 8'($urandom);
         end
      end
      chk("busy_ign_ndone", 32'(ndone), 1);
      chk("busy_ign_cycle", 32'(dcyc), 12);
      chk("busy_ign_out", 32'(dout), 126);
      chk("busy_ign_busy_e12", 32'(busy), 0);
      step();                                   // E13 accepts in=34
      chk("busy_ign_accept_e13", 32'(busy), 1);
      start = 1'b0;
      dcyc  = 0;
      seen2 = 1'b0;
      for (int c = 14; c <= 40 && !seen2; c++) begin
         step();
         if (done === 1'b1) begin
            seen2 = 1'b1;
            dcyc  = c;
         end
      end
      chk("busy_ign_cycle2", 32'(dcyc), 25);
      chk("busy_ign_out2", 32'(dout), 96);
      step();

      // ---- back-to-back with start held high ----
      for (int e = 0; e < 64; e++) vals[e] = 8'($urandom);
      start = 1'b1;
      for (int e = 0; e < 52; e++) begin
         din = vals[e];
         step();                                // edge e
         chk("b2b_done", 32'(done), 32'((e % 13) == 12));
         if ((e % 13) == 12) begin
            chk("b2b_out", 32'(dout), 32'(ref_inv(int'(vals[e - 12]))));
            chk("b2b_zero_err", 32'(zero_err), 32'((int'(vals[e - 12]) % 251) == 0));
         end
      end
      start = 1'b0;
      step();
      chk("b2b_idle_busy", 32'(busy), 0);
      run_op(8'd5, res);                        // leaves a nonzero out behind

      // ---- reset in the middle of an operation ----
      start = 1'b1;
      din   = 8'd20;
      step();                                   // E0
      start = 1'b0;
      for (int c = 1; c <= 5; c++) step();
      chk("midrst_busy_before", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out", 32'(dout), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_zero_err", 32'(zero_err), 0);
      step();
      step();
      #2 rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (done === 1'b1) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 0);
      chk("midrst_idle_busy", 32'(busy), 0);
      run_op(8'd20, res);
      chk("midrst_inv20", 32'(res), 113);

      // ---- sweep: every nonzero residue multiplies back to 1 ----
      for (int a = 1; a <= 250; a++) begin
         run_op(8'(a), res);
         chk("sweep_prod", 32'((a * int'(res)) % 251), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Time limit so the run always ends on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gf251_inv.md
Name: gf251_inv

Overview:
- Sequential GF(251) multiplicative inverse unit. It undoes a gf251_mul product: the inverse multiplies back to 1.
- Computes out = in^249 mod 251 (Fermat) by left-to-right square-and-multiply.
- Uses one internal single-cycle mod-251 multiplier.
- Feeds gf251 division paths (a/b = a * inv(b)). Same start/done handshake style as gf251_mul.

Parameters:
- none. Modulus 251 and exponent 249 are fixed.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when busy=0.
- in  input  8  operand. Captured on the accepting edge.
- out  output  8  inverse result. Holds until the next completion.
- done  output  1  one-cycle pulse; out is valid in the same cycle.
- busy  output  1  high while an operation is in flight.
- zero_err  output  1  valid with done; 1 when the reduced operand was 0.

Behaviour:
- Reset (async assert, sync release): out=0, done=0, busy=0, zero_err=0, FSM=IDLE. All internal registers cleared.
- Operand reduction on capture: values 251..255 become in-251, so 251 maps to 0 and 252 maps to 1.
- Exponent 249 = 8'b1111_1001. The MSB is consumed by initialisation. Remaining bits 6..0 = 1,1,1,1,0,0,1.
- Internal multiplier: 8x8 -> 16-bit product, reduced mod 251 combinationally, result always in [0,250].
- FSM states: IDLE, SQR, MUL.
- IDLE, start=1 at edge E0: base<=red(in), acc<=red(in), idx<=6, busy<=1, state<=SQR.
- SQR: acc<=acc*acc. If bit[idx]=1, go to MUL. Otherwise decrement idx and stay in SQR. bit[0] is never 0, so SQR never terminates the run.
- MUL: acc<=acc*base. If idx=0: out<=acc*base, done<=1, zero_err<=(base==0), busy<=0, state<=IDLE. Otherwise decrement idx and go to SQR.
- Fixed sequence: 7 SQR + 5 MUL = 12 edges after E0. done is high in the cycle following edge E12, for exactly one cycle.
- Fixed latency: 12 cycles from the accepting edge to done. Minimum start-to-start spacing is 13 cycles.
- start while busy=1: ignored. No queueing, in ignored, running operation unaffected.
- start held high continuously: a new operation is accepted on the first edge after done (busy=0 in that cycle).
- Zero operand: runs the full sequence. out=0, zero_err=1 with done.
- zero_err is 0 at every other completion and is updated only at completion.
- Reset asserted mid-operation: immediately aborts, outputs at reset values, no done is generated.
- done is never asserted without a preceding accepted start.

Test Plan:
- Reset then idle: i_rst_n low 3 cycles, start=0 -> out=0, done=0, busy=0, zero_err=0 throughout.
- Single ops with start pulsed 1 cycle each; check done exactly 12 cycles after the accepting edge and out:
  - in=1 -> out=1.
  - in=2 -> out=126.
  - in=20 -> out=113.
  - in=34 -> out=96.
  - in=250 -> out=250.
  - zero_err=0 on each.
- Edge operands:
  - in=0 -> out=0, zero_err=1.
  - in=251 -> out=0, zero_err=1.
  - in=252 -> out=1, zero_err=0.
- Start while busy: accept in=2, pulse start with in=34 at cycles 3 and 11 -> single done, out=126, busy drops after E12. Then start with in=34 is accepted at E13 -> out=96 at E25.
- Back-to-back: start held high with in changing each cycle -> accepts occur every 13 cycles, and each result matches the inverse of the value present on the accepting edge.
- Reset mid-op: accept in=20, assert i_rst_n low at cycle 6 -> outputs clear asynchronously, no done follows. After release, in=20 -> out=113.
- Exhaustive sweep: all in=1..250 -> (in*out) mod 251 == 1 for every value.
